// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo_param
//  Summary  : Single-clock parametrised FIFO with threshold flags, occupancy
//             count, standard/FWFT read modes and sticky error flags.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter bit FWFT      = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wen,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     ren,
    input  logic                     clr_err,
    output logic [DATA_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int           AW        = $clog2(DEPTH);
    localparam logic [AW:0]  c_DEPTH   = DEPTH[AW:0];
    localparam logic [AW:0]  c_AF      = AF_THRESH[AW:0];
    localparam logic [AW:0]  c_AE      = AE_THRESH[AW:0];
    localparam logic [AW-1:0] c_PTR_ONE = AW'(1);
    localparam logic [AW:0]  c_CNT_ONE = (AW + 1)'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [AW:0]       r_count;
    logic              r_ovf;
    logic              r_udf;

    logic w_full;
    logic w_empty;
    logic w_wr;
    logic w_rd;

    assign w_full  = (r_count == c_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_wr    = wen && !w_full;
    assign w_rd    = ren && !w_empty;

    assign full         = w_full;
    assign empty        = w_empty;
    assign almost_full  = (r_count >= c_AF);
    assign almost_empty = (r_count <= c_AE);
    assign count        = r_count;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

    // Storage is deliberately left out of reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + c_PTR_ONE;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: ;
            endcase
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (wen && w_full) begin
                r_ovf <= 1'b1;
            end else if (clr_err) begin
                r_ovf <= 1'b0;
            end
            if (ren && w_empty) begin
                r_udf <= 1'b1;
            end else if (clr_err) begin
                r_udf <= 1'b0;
            end
        end
    end

    generate
        if (FWFT) begin : g_fwft
            logic [DATA_W-1:0] r_hold;

            // Remembers the last popped head so rdata stays stable while empty.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_hold <= '0;
                end else if (w_rd) begin
                    r_hold <= r_mem[r_rptr];
                end
            end

            assign rdata = w_empty ? r_hold : r_mem[r_rptr];
        end else begin : g_std
            logic [DATA_W-1:0] r_rdata;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_rdata <= '0;
                end else if (w_rd) begin
                    r_rdata <= r_mem[r_rptr];
                end
            end

            assign rdata = r_rdata;
        end
    endgenerate

endmodule
`default_nettype wire
